// File: rtl/dlf_pkg.sv
// Shared DL-Float result-collector types: datapath width, IEEE-style flag indices, unit channel ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dlf_pkg;

  localparam int DLF_W      = 16;
  localparam int DLF_NFLAGS = 5;

  // Bit positions inside a flag vector {NV, DZ, OF, UF, NX}
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  // Channel ids keep the encoding of the old fixed 8:1 output select
  typedef enum logic [2:0] {
    CH_ADD  = 3'd0,
    CH_SUB  = 3'd1,
    CH_MUL  = 3'd2,
    CH_DIV  = 3'd3,
    CH_MAC  = 3'd4,
    CH_SQRT = 3'd5,
    CH_NORM = 3'd6,
    CH_DP   = 3'd7
  } dlf_ch_e;

  typedef logic [DLF_NFLAGS-1:0] dlf_flags_t;

endpackage

// File: rtl/dlf_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after i_rr_ptr (wrapping).
// Latency: purely combinational.
// Backpressure: i_en low forces grant to zero (caller withholds it when it cannot accept).
// Ports: i_en enable, i_req request vector, i_rr_ptr search start,
//        o_grant one-hot grant, o_grant_id binary index of the granted channel.
module dlf_rr_arbiter #(
  parameter  int N   = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic           i_en,
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_rr_ptr,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_grant_id
);

  always_comb begin
    int   w_idx;
    logic w_found;
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int i = 0; i < N; i++) begin
      // Rotate the search so i_rr_ptr has the highest priority
      w_idx = int'(i_rr_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (i_en && !w_found && i_req[w_idx]) begin
        w_found         = 1'b1;
        o_grant[w_idx]  = 1'b1;
        o_grant_id      = IDW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/dlf_result_collector.sv
// Collects results from N arithmetic units round-robin into a DEPTH-entry FIFO tagged with channel id.
// Latency: transfer at edge t is visible at the FIFO head after edge t; no empty bypass.
// Backpressure: grants only while a slot is free (or the head pops this cycle); full + stalled -> no grant.
// Ports: i_clk, i_reset (sync, active-high); i_in_valid/i_in_data/o_in_ready per-channel producers;
//        o_out_valid/o_out_data/o_out_id/i_out_ready head handshake; o_count occupancy.
// Optional DLF_RESCOL_FLAGS_EN: i_in_flags, o_out_flags, o_sticky_flags, i_sticky_clr.
module dlf_result_collector
  import dlf_pkg::*;
#(
  parameter  int W     = DLF_W,
  parameter  int N     = 8,
  parameter  int DEPTH = 4,
  localparam int IDW   = $clog2(N),
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N-1:0]     i_in_valid,
  input  logic [N*W-1:0]   i_in_data,
  output logic [N-1:0]     o_in_ready,
  output logic             o_out_valid,
  output logic [W-1:0]     o_out_data,
  output logic [IDW-1:0]   o_out_id,
  input  logic             i_out_ready,
  output logic [CW-1:0]    o_count
`ifdef DLF_RESCOL_FLAGS_EN
  ,
  input  logic [N*DLF_NFLAGS-1:0] i_in_flags,
  output dlf_flags_t              o_out_flags,
  output dlf_flags_t              o_sticky_flags,
  input  logic                    i_sticky_clr
`endif
);

  logic [W-1:0]   r_mem_data [DEPTH];
  logic [IDW-1:0] r_mem_id   [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [IDW-1:0] r_rr_ptr;

  logic           w_nonempty;
  logic           w_pop;
  logic           w_push_ok;
  logic           w_push;
  logic [N-1:0]   w_grant;
  logic [IDW-1:0] w_grant_id;

  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty & i_out_ready;
  // A full FIFO can still accept when its head leaves in the same cycle
  assign w_push_ok  = !i_reset && ((r_count < CW'(DEPTH)) || w_pop);

  dlf_rr_arbiter #(.N(N)) u_arb (
    .i_en       (w_push_ok),
    .i_req      (i_in_valid),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  assign w_push     = |w_grant;
  assign o_in_ready = w_grant;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_grant_id == IDW'(N - 1)) ? '0 : w_grant_id + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is intentionally not reset; occupancy alone decides validity
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= i_in_data[int'(w_grant_id)*W +: W];
      r_mem_id[r_wr_ptr]   <= w_grant_id;
    end
  end

  assign o_out_valid = w_nonempty;
  assign o_out_data  = w_nonempty ? r_mem_data[r_rd_ptr] : '0;
  assign o_out_id    = w_nonempty ? r_mem_id[r_rd_ptr]   : '0;
  assign o_count     = r_count;

`ifdef DLF_RESCOL_FLAGS_EN
  dlf_flags_t r_mem_flg [DEPTH];
  dlf_flags_t r_sticky;
  dlf_flags_t w_head_flg;

  assign w_head_flg = w_nonempty ? r_mem_flg[r_rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem_flg[r_wr_ptr] <= i_in_flags[int'(w_grant_id)*DLF_NFLAGS +: DLF_NFLAGS];
  end

  // Clear wins over history, but a flag popped in the same cycle is still recorded
  always_ff @(posedge i_clk) begin
    if (i_reset)           r_sticky <= '0;
    else if (i_sticky_clr) r_sticky <= w_pop ? w_head_flg : '0;
    else if (w_pop)        r_sticky <= r_sticky | w_head_flg;
  end

  assign o_out_flags    = w_head_flg;
  assign o_sticky_flags = r_sticky;
`endif

endmodule

// File: tb/tb_dlf_result_collector.sv
// Scoreboard bench for dlf_result_collector: a cycle model predicts grants and occupancy,
// expected {flags, id, data} are queued at each predicted transfer and compared at each pop.
module tb_dlf_result_collector;
  import dlf_pkg::*;

  localparam int W     = 16;
  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int IDW   = 3;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [IDW-1:0]   out_id;
  logic             out_ready;
  logic [CW-1:0]    count;
`ifdef DLF_RESCOL_FLAGS_EN
  logic [N*5-1:0]   in_flags;
  logic [4:0]       out_flags;
  logic [4:0]       sticky_flags;
  logic             sticky_clr;
`endif

  always #5 clk = ~clk;

  dlf_result_collector #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_out_id    (out_id),
    .i_out_ready (out_ready),
    .o_count     (count)
`ifdef DLF_RESCOL_FLAGS_EN
    ,
    .i_in_flags     (in_flags),
    .o_out_flags    (out_flags),
    .o_sticky_flags (sticky_flags),
    .i_sticky_clr   (sticky_clr)
`endif
  );

  typedef struct packed {
    logic [4:0]     flg;
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } exp_t;

  exp_t sb[$];
  int   m_count = 0;
  int   m_rr    = 0;
  int   last_grant;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check outputs against the model at negedge, advance the model, return #1 after posedge
  task automatic step();
    logic [N-1:0] exp_rdy;
    logic         pop, push_ok, found;
    int           k, gk;
    exp_t         e;
    @(negedge clk);
    exp_rdy = '0;
    found   = 1'b0;
    gk      = 0;
    pop     = (m_count != 0) && out_ready;
    push_ok = !reset && ((m_count < DEPTH) || pop);
    for (int i = 0; i < N; i++) begin
      k = (m_rr + i) % N;
      if (push_ok && !found && in_valid[k]) begin
        found      = 1'b1;
        exp_rdy[k] = 1'b1;
        gk         = k;
      end
    end
    last_grant = -1;
    for (int i = 0; i < N; i++) if (in_ready[i]) last_grant = i;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_count != 0);
    check("count", count, m_count);
    if (m_count != 0) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb[0];
        check("out_data", out_data, e.data);
        check("out_id", out_id, e.id);
`ifdef DLF_RESCOL_FLAGS_EN
        check("out_flags", out_flags, e.flg);
`endif
      end
    end else begin
      check("empty_data", out_data, 0);
      check("empty_id", out_id, 0);
    end
    if (reset) begin
      m_count = 0;
      m_rr    = 0;
      sb.delete();
    end else begin
      if (pop && sb.size() > 0) void'(sb.pop_front());
      if (found) begin
        e.data = in_data[gk*W +: W];
        e.id   = IDW'(gk);
`ifdef DLF_RESCOL_FLAGS_EN
        e.flg  = in_flags[gk*5 +: 5];
`else
        e.flg  = 5'b0;
`endif
        sb.push_back(e);
        m_rr = (gk + 1) % N;
      end
      m_count = m_count + (found ? 1 : 0) - (pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef DLF_RESCOL_FLAGS_EN
    in_flags   = '0;
    sticky_clr = 1'b0;
`endif
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, then a single push on the mul channel
    step();
    check("rst_out_data", out_data, 0);
    check("rst_count", count, 0);
    in_data[2*W +: W] = 16'h3C00;
    in_valid = 8'b0000_0100;
    step();
    in_valid = '0;
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 16'h3C00);
    check("t1_id", out_id, 2);
    out_ready = 1'b1;
    repeat (2) step();

    // Round-robin order with all channels requesting, starting fresh from ch0
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'h1000 + 16'(i);
    in_valid = '1;
    for (int i = 0; i < 9; i++) begin
      step();
      check("rr_order", last_grant, i % 8);
    end
    in_valid = '0;
    repeat (2) step();

    // Fill to full with the consumer stalled, then stream at full rate
    out_ready = 1'b0;
    in_data[0*W +: W] = 16'hA000;
    in_data[5*W +: W] = 16'hA005;
    in_valid = 8'b0010_0001;
    repeat (5) step();
    check("t3_full_count", count, 4);
    check("t3_full_rdy", in_ready, 0);
    out_ready = 1'b1;
    repeat (4) begin
      step();
      check("t3_count_hold", count, 4);
    end
    in_valid = '0;
    repeat (5) step();
    check("t3_drained", count, 0);

    // Pointer wrap: ten results through a 4-deep FIFO in order
    for (int i = 1; i <= 10; i++) begin
      in_data[3*W +: W] = 16'(i);
      in_valid = 8'b0000_1000;
      step();
    end
    in_valid = '0;
    repeat (3) step();
    check("t4_drained", count, 0);

    // Reset with three buffered results discards them and restarts arbitration at ch0
    out_ready = 1'b0;
    in_valid = 8'b1110_0000;
    repeat (3) step();
    check("t5_count3", count, 3);
    in_valid = '1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_count", count, 0);
    check("t5_rst_valid", out_valid, 0);
    step();
    check("t5_rr_restart", last_grant, 0);
    in_valid = '0;
    out_ready = 1'b1;
    repeat (3) step();

`ifdef DLF_RESCOL_FLAGS_EN
    // Sticky flags accumulate over pops and clear on request
    out_ready  = 1'b0;
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    in_flags[1*5 +: 5] = 5'b00100;
    in_data[1*W +: W]  = 16'h1111;
    in_valid = 8'b0000_0010;
    step();
    in_flags[2*5 +: 5] = 5'b00001;
    in_data[2*W +: W]  = 16'h2222;
    in_valid = 8'b0000_0100;
    step();
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (2) step();
    check("sticky_or", sticky_flags, 5'b00101);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("sticky_clr", sticky_flags, 5'b00000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
